// File: rtl/proc_pkg.sv
// Shared processor datapath constants and the register-address type.
// Also holds the range check used wherever an address may exceed the file depth.
package proc_pkg;

  localparam int WORD_W  = 16;
  localparam int REG_CNT = 32;
  localparam int REG_AW  = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Depth need not be a power of two, so the top address codes may be unmapped.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_mux_2r1w_mux.sv
// Combinational N-to-1 selector: one-hot decode of sel, then AND-OR reduction.
// Select codes at or above N decode to no hit, so the output is zero.
module mux_nto1 #(
  parameter int WIDTH = 16,
  parameter int N     = 32,
  parameter int SW    = 5
) (
  input  logic [N*WIDTH-1:0] din,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   dout
);

  logic [N-1:0]     hit;
  logic [WIDTH-1:0] term [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_term
      assign hit[gi]  = (sel == SW'(gi));
      assign term[gi] = din[gi*WIDTH +: WIDTH] & {WIDTH{hit[gi]}};
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | term[i];
    end
  end

endmodule

// File: rtl/regfile_mux_2r1w.sv
// Register file with one write port and two registered read ports, optional
// write-to-read bypass, optional hardwired zero register and address-error flag.
module regfile_mux_2r1w
  import proc_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = REG_CNT,
  parameter int AW       = REG_AW,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic             addr_err
);

  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic                   wr_ok;
  logic [WIDTH-1:0]       sel_a;
  logic [WIDTH-1:0]       sel_b;
  logic [WIDTH-1:0]       rdata_a_next;
  logic [WIDTH-1:0]       rdata_b_next;
  logic                   addr_err_next;

  // A write lands only on a mapped, writable register.
  assign wr_ok = we && addr_in_range(32'(waddr), DEPTH) && !(ZERO_REG && waddr == '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      if (ZERO_REG && gi == 0) begin : g_zero
        assign mem_flat[gi*WIDTH +: WIDTH] = '0;
      end else begin : g_reg
        logic [WIDTH-1:0] word_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_reg <= '0;
          end else if (wr_ok && waddr == AW'(gi)) begin
            word_reg <= wdata;
          end
        end
        assign mem_flat[gi*WIDTH +: WIDTH] = word_reg;
      end
    end
  endgenerate

  mux_nto1 #(.WIDTH(WIDTH), .N(DEPTH), .SW(AW)) u_mux_a (
    .din  (mem_flat),
    .sel  (raddr_a),
    .dout (sel_a)
  );

  mux_nto1 #(.WIDTH(WIDTH), .N(DEPTH), .SW(AW)) u_mux_b (
    .din  (mem_flat),
    .sel  (raddr_b),
    .dout (sel_b)
  );

  // wr_ok already excludes the zero register and unmapped addresses.
  assign rdata_a_next = (BYPASS && wr_ok && waddr == raddr_a) ? wdata : sel_a;
  assign rdata_b_next = (BYPASS && wr_ok && waddr == raddr_b) ? wdata : sel_b;

  assign addr_err_next = (we   && !addr_in_range(32'(waddr),   DEPTH)) ||
                         (re_a && !addr_in_range(32'(raddr_a), DEPTH)) ||
                         (re_b && !addr_in_range(32'(raddr_b), DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      addr_err <= addr_err_next;
      if (re_a) rdata_a <= rdata_a_next;
      if (re_b) rdata_b <= rdata_b_next;
    end
  end

endmodule

// File: tb/tb_regfile_mux_2r1w.sv
// Drives four parameter corners of the register file with shared stimulus and
// compares each against an array-based reference model every cycle.
module tb_regfile_mux_2r1w;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [4:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [4:0]  raddr_b = '0;

  logic [15:0] rda [NI];
  logic [15:0] rdb [NI];
  logic        va [NI];
  logic        vb [NI];
  logic        aerr [NI];

  // Corner table: depth, bypass, zero register, matching the instances below.
  int dep [NI] = '{32, 24, 24, 32};
  bit byp [NI] = '{1, 0, 1, 0};
  bit zr  [NI] = '{1, 0, 0, 1};

  logic [15:0] mm [NI][32];
  logic [15:0] ea [NI];
  logic [15:0] eb [NI];
  logic        eva [NI];
  logic        evb [NI];
  logic        eerr [NI];

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  regfile_mux_2r1w #(.WIDTH(16), .DEPTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rda[0]), .rdata_b(rdb[0]), .rvalid_a(va[0]), .rvalid_b(vb[0]), .addr_err(aerr[0]));

  regfile_mux_2r1w #(.WIDTH(16), .DEPTH(24), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rda[1]), .rdata_b(rdb[1]), .rvalid_a(va[1]), .rvalid_b(vb[1]), .addr_err(aerr[1]));

  regfile_mux_2r1w #(.WIDTH(16), .DEPTH(24), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rda[2]), .rdata_b(rdb[2]), .rvalid_a(va[2]), .rvalid_b(vb[2]), .addr_err(aerr[2]));

  regfile_mux_2r1w #(.WIDTH(16), .DEPTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rda[3]), .rdata_b(rdb[3]), .rvalid_a(va[3]), .rvalid_b(vb[3]), .addr_err(aerr[3]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mread(input int k, input int a);
    if (a >= dep[k] || (zr[k] && a == 0)) return 16'h0;
    return mm[k][a];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 32; a++) mm[k][a] = 16'h0;
      ea[k] = 16'h0; eb[k] = 16'h0;
      eva[k] = 1'b0; evb[k] = 1'b0; eerr[k] = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rdata_a[%0d]", k), rda[k], ea[k]);
      chk($sformatf("rdata_b[%0d]", k), rdb[k], eb[k]);
      chk($sformatf("rvalid_a[%0d]", k), 16'(va[k]), 16'(eva[k]));
      chk($sformatf("rvalid_b[%0d]", k), 16'(vb[k]), 16'(evb[k]));
      chk($sformatf("addr_err[%0d]", k), 16'(aerr[k]), 16'(eerr[k]));
    end
  endtask

  // One clock of stimulus; the model predicts the post-edge outputs from
  // pre-write contents, then commits the write.
  task automatic step(input logic w, input int wa, input logic [15:0] wd,
                      input logic ea_en, input int ra, input logic eb_en, input int rb);
    logic writable;
    we = w; waddr = 5'(wa); wdata = wd;
    re_a = ea_en; raddr_a = 5'(ra); re_b = eb_en; raddr_b = 5'(rb);
    for (int k = 0; k < NI; k++) begin
      writable = w && wa < dep[k] && !(zr[k] && wa == 0);
      if (ea_en) ea[k] = (byp[k] && writable && wa == ra) ? wd : mread(k, ra);
      if (eb_en) eb[k] = (byp[k] && writable && wa == rb) ? wd : mread(k, rb);
      eva[k]  = ea_en;
      evb[k]  = eb_en;
      eerr[k] = (w && wa >= dep[k]) || (ea_en && ra >= dep[k]) || (eb_en && rb >= dep[k]);
      if (writable) mm[k][wa] = wd;
    end
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn we=%0d waddr=%0d wdata=%h re_a=%0d ra=%0d re_b=%0d rb=%0d -> u0 a=%h b=%h err=%0d",
               w, wa, wd, ea_en, ra, eb_en, rb, rda[0], rdb[0], aerr[0]);
    compare_all();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst rdata_a[%0d]", k), rda[k], 16'h0);
      chk($sformatf("rst rdata_b[%0d]", k), rdb[k], 16'h0);
      chk($sformatf("rst rvalid_a[%0d]", k), 16'(va[k]), 16'h0);
      chk($sformatf("rst rvalid_b[%0d]", k), 16'(vb[k]), 16'h0);
      chk($sformatf("rst addr_err[%0d]", k), 16'(aerr[k]), 16'h0);
    end
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    $display("txn reset pulse done");
  endtask

  initial begin
    int w, wa, ra, rb;
    logic ren_a, ren_b;
    model_clear();
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;

    // Some traffic so the later reset lands on a non-empty file.
    for (int i = 0; i < 20; i++)
      step(1'b1, $urandom_range(0, 31), 16'($urandom), 1'b1, $urandom_range(0, 31), 1'b1, $urandom_range(0, 31));

    reset_mid();
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 0, 16'h0, 1'b1, a, 1'b1, a);
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("postrst a%0d rdata_a[%0d]", a, k), rda[k], 16'h0);
        chk($sformatf("postrst a%0d rdata_b[%0d]", a, k), rdb[k], 16'h0);
      end
    end

    step(1'b1, 5, 16'hBEEF, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 16'h0, 1'b1, 5, 1'b0, 0);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("wr_rd rdata_a[%0d]", k), rda[k], 16'hBEEF);
      chk($sformatf("wr_rd rvalid_a[%0d]", k), 16'(va[k]), 16'h1);
    end

    step(1'b1, 7, 16'h1234, 1'b0, 0, 1'b1, 7);
    chk("bypass rdata_b[0]", rdb[0], 16'h1234);
    chk("bypass rdata_b[1]", rdb[1], 16'h0000);
    chk("bypass rdata_b[2]", rdb[2], 16'h1234);
    chk("bypass rdata_b[3]", rdb[3], 16'h0000);

    step(1'b1, 0, 16'hFFFF, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 16'h0, 1'b1, 0, 1'b1, 0);
    chk("zero rdata_a[0]", rda[0], 16'h0000);
    chk("zero rdata_b[0]", rdb[0], 16'h0000);
    chk("zero rdata_a[1]", rda[1], 16'hFFFF);
    chk("zero rdata_b[2]", rdb[2], 16'hFFFF);
    chk("zero rdata_a[3]", rda[3], 16'h0000);

    step(1'b0, 0, 16'h0, 1'b1, 30, 1'b0, 0);
    chk("oor rdata_a[1]", rda[1], 16'h0000);
    chk("oor addr_err[1]", 16'(aerr[1]), 16'h1);
    chk("oor addr_err[0]", 16'(aerr[0]), 16'h0);
    step(1'b1, 30, 16'hABCD, 1'b0, 0, 1'b0, 0);
    chk("oor wr addr_err[2]", 16'(aerr[2]), 16'h1);
    step(1'b0, 0, 16'h0, 1'b0, 0, 1'b0, 0);
    chk("oor clear addr_err[1]", 16'(aerr[1]), 16'h0);
    for (int a = 0; a < 32; a++) step(1'b0, 0, 16'h0, 1'b1, a, 1'b1, 31 - a);
    chk("oor rdata_b[0] addr 0", rdb[0], 16'h0000);

    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) reset_mid();
      w     = int'($urandom_range(0, 1));
      wa    = int'($urandom_range(0, 31));
      ren_a = 1'($urandom_range(0, 3) != 0);
      ren_b = 1'($urandom_range(0, 3) != 0);
      ra    = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      rb    = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 31));
      step(1'(w), wa, 16'($urandom), ren_a, ra, ren_b, rb);
      if (i % 1000 == 999) $display("txn random block ending at cycle %0d, errors so far %0d", i, errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
